// File: rtl/ct_ciu_ncq_excl_req.sv
// Initiator-side exclusive-access sequencer: turns LR/SC into locked AR/AW bursts and tracks a local reservation.
// Optional reservation lifetime counter enabled by defining CT_CIU_EXCL_TIMEOUT_EN.
module ct_ciu_ncq_excl_req #(
    parameter int ADDRW   = 40,
    parameter int TOW     = 8,
    parameter int TIMEOUT = 255
) (
    input  logic             forever_cpuclk,
    input  logic             cpurst_b,
    input  logic             lr_req,
    input  logic [ADDRW-1:0] lr_addr,
    output logic             lr_ack,
    input  logic             sc_req,
    input  logic [ADDRW-1:0] sc_addr,
    output logic             sc_ack,
    input  logic             snoop_clr,
    output logic             ar_vld,
    input  logic             ar_ready,
    output logic [ADDRW-1:0] ar_addr,
    output logic             ar_lock,
    input  logic             r_vld,
    input  logic             r_last,
    input  logic [1:0]       r_resp,
    output logic             aw_vld,
    input  logic             aw_ready,
    output logic [ADDRW-1:0] aw_addr,
    output logic             aw_lock,
    input  logic             b_vld,
    input  logic [1:0]       b_resp,
    output logic             lr_done,
    output logic             lr_excl_ok,
    output logic             sc_done,
    output logic             sc_fail,
    output logic             rsv_vld,
    output logic [ADDRW-1:0] rsv_addr
);

    // Handshake: a request (lr_req/sc_req) is held by the core until its ack; ar/aw valid
    // stays asserted with stable address until the matching ready is seen high on a clock edge.
    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_AR    = 3'd1,
        ST_RWAIT = 3'd2,
        ST_AW    = 3'd3,
        ST_BWAIT = 3'd4,
        ST_SCF   = 3'd5
    } state_t;

    localparam logic [1:0] RESP_EXOKAY = 2'b01;

    state_t           state_q;
    logic [ADDRW-1:0] addr_q;
    logic             kill_q;
    logic             lr_done_q;
    logic             lr_ok_q;
    logic             sc_done_q;
    logic             sc_fail_q;
    logic             rsv_vld_q;
    logic             rsv_vld_d;
    logic [ADDRW-1:0] rsv_addr_q;
    logic [ADDRW-1:0] rsv_addr_d;

    logic is_idle;
    logic sc_hit;
    logic r_done;
    logic r_excl;
    logic b_done;

    assign is_idle = (state_q == ST_IDLE);
    assign sc_ack  = is_idle & sc_req;
    assign lr_ack  = is_idle & lr_req & ~sc_req;
    assign sc_hit  = rsv_vld_q & (sc_addr == rsv_addr_q) & ~snoop_clr;
    assign r_done  = (state_q == ST_RWAIT) & r_vld & r_last;
    // A snoop in the completing cycle beats an EXOKAY.
    assign r_excl  = (r_resp == RESP_EXOKAY) & ~kill_q & ~snoop_clr;
    assign b_done  = (state_q == ST_BWAIT) & b_vld;

`ifdef CT_CIU_EXCL_TIMEOUT_EN
    logic [TOW-1:0] to_q;
    logic [TOW-1:0] to_d;
    logic           to_expire;

    assign to_expire = rsv_vld_q & is_idle & (to_q == '0);

    always_comb begin
        to_d = to_q;
        if (r_done && r_excl) begin
            to_d = TOW'(TIMEOUT);
        end else if (rsv_vld_q && is_idle && (to_q != '0)) begin
            to_d = to_q - 1'b1;
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            to_q <= '0;
        end else begin
            to_q <= to_d;
        end
    end
`else
    logic to_expire;
    assign to_expire = 1'b0;
`endif

    // Later assignments take priority; snoop_clr is last so it always wins.
    always_comb begin
        rsv_vld_d  = rsv_vld_q;
        rsv_addr_d = rsv_addr_q;
        if (lr_ack) begin
            rsv_vld_d = 1'b0;
        end
        if (r_done) begin
            rsv_vld_d = r_excl;
            if (r_excl) begin
                rsv_addr_d = addr_q;
            end
        end
        if (b_done || (state_q == ST_SCF) || to_expire || snoop_clr) begin
            rsv_vld_d = 1'b0;
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            rsv_vld_q  <= 1'b0;
            rsv_addr_q <= '0;
        end else begin
            rsv_vld_q  <= rsv_vld_d;
            rsv_addr_q <= rsv_addr_d;
        end
    end

    always_ff @(posedge forever_cpuclk or negedge cpurst_b) begin
        if (!cpurst_b) begin
            state_q   <= ST_IDLE;
            addr_q    <= '0;
            kill_q    <= 1'b0;
            lr_done_q <= 1'b0;
            lr_ok_q   <= 1'b0;
            sc_done_q <= 1'b0;
            sc_fail_q <= 1'b0;
        end else begin
            lr_done_q <= 1'b0;
            lr_ok_q   <= 1'b0;
            sc_done_q <= 1'b0;
            sc_fail_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (sc_req) begin
                        addr_q <= sc_addr;
                        if (sc_hit) begin
                            state_q <= ST_AW;
                        end else begin
                            // Reported during SCF, one cycle after the ack.
                            state_q   <= ST_SCF;
                            sc_done_q <= 1'b1;
                            sc_fail_q <= 1'b1;
                        end
                    end else if (lr_req) begin
                        addr_q  <= lr_addr;
                        kill_q  <= 1'b0;
                        state_q <= ST_AR;
                    end
                end
                ST_AR: begin
                    if (snoop_clr) begin
                        kill_q <= 1'b1;
                    end
                    if (ar_ready) begin
                        state_q <= ST_RWAIT;
                    end
                end
                ST_RWAIT: begin
                    if (snoop_clr) begin
                        kill_q <= 1'b1;
                    end
                    if (r_vld && r_last) begin
                        lr_done_q <= 1'b1;
                        lr_ok_q   <= r_excl;
                        state_q   <= ST_IDLE;
                    end
                end
                ST_AW: begin
                    if (aw_ready) begin
                        state_q <= ST_BWAIT;
                    end
                end
                ST_BWAIT: begin
                    if (b_vld) begin
                        sc_done_q <= 1'b1;
                        sc_fail_q <= (b_resp != RESP_EXOKAY);
                        state_q   <= ST_IDLE;
                    end
                end
                ST_SCF: begin
                    state_q <= ST_IDLE;
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign ar_vld     = (state_q == ST_AR);
    assign ar_lock    = ar_vld;
    assign ar_addr    = addr_q;
    assign aw_vld     = (state_q == ST_AW);
    assign aw_lock    = aw_vld;
    assign aw_addr    = addr_q;
    assign lr_done    = lr_done_q;
    assign lr_excl_ok = lr_ok_q;
    assign sc_done    = sc_done_q;
    assign sc_fail    = sc_fail_q;
    assign rsv_vld    = rsv_vld_q;
    assign rsv_addr   = rsv_addr_q;

endmodule

// File: tb/tb_ct_ciu_ncq_excl_req.sv
// Directed bench for ct_ciu_ncq_excl_req: LR/SC sequences, snoop kills, local SC fails, request priority.
module tb_ct_ciu_ncq_excl_req;
  localparam int ADDRW = 40;

  logic             clk;
  logic             rst_n;
  logic             lr_req;
  logic [ADDRW-1:0] lr_addr;
  logic             lr_ack;
  logic             sc_req;
  logic [ADDRW-1:0] sc_addr;
  logic             sc_ack;
  logic             snoop_clr;
  logic             ar_vld;
  logic             ar_ready;
  logic [ADDRW-1:0] ar_addr;
  logic             ar_lock;
  logic             r_vld;
  logic             r_last;
  logic [1:0]       r_resp;
  logic             aw_vld;
  logic             aw_ready;
  logic [ADDRW-1:0] aw_addr;
  logic             aw_lock;
  logic             b_vld;
  logic [1:0]       b_resp;
  logic             lr_done;
  logic             lr_excl_ok;
  logic             sc_done;
  logic             sc_fail;
  logic             rsv_vld;
  logic [ADDRW-1:0] rsv_addr;

  int tests_run = 0;
  int tests_failed = 0;

  // Entry: bit1 = 1 for SC completion, 0 for LR; bit0 = sc_fail or lr_excl_ok.
  logic [1:0] exp_q[$];

  ct_ciu_ncq_excl_req #(.ADDRW(ADDRW), .TOW(8), .TIMEOUT(4)) dut (
    .forever_cpuclk(clk),
    .cpurst_b(rst_n),
    .lr_req(lr_req),
    .lr_addr(lr_addr),
    .lr_ack(lr_ack),
    .sc_req(sc_req),
    .sc_addr(sc_addr),
    .sc_ack(sc_ack),
    .snoop_clr(snoop_clr),
    .ar_vld(ar_vld),
    .ar_ready(ar_ready),
    .ar_addr(ar_addr),
    .ar_lock(ar_lock),
    .r_vld(r_vld),
    .r_last(r_last),
    .r_resp(r_resp),
    .aw_vld(aw_vld),
    .aw_ready(aw_ready),
    .aw_addr(aw_addr),
    .aw_lock(aw_lock),
    .b_vld(b_vld),
    .b_resp(b_resp),
    .lr_done(lr_done),
    .lr_excl_ok(lr_excl_ok),
    .sc_done(sc_done),
    .sc_fail(sc_fail),
    .rsv_vld(rsv_vld),
    .rsv_addr(rsv_addr)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    tests_run++;
    assert (obs === exp) else begin
      tests_failed++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // scoreboard: completions are popped in order
  always @(negedge clk) begin
    if (rst_n && (lr_done || sc_done)) begin
      if (exp_q.size() == 0) begin
        tests_run++;
        tests_failed++;
        $error("FAIL unexpected_done observed lr_done=%b sc_done=%b expected none", lr_done, sc_done);
      end else begin
        logic [1:0] e;
        e = exp_q.pop_front();
        chk("done_kind", {62'd0, lr_done, sc_done}, e[1] ? 64'd1 : 64'd2);
        chk("done_flag", e[1] ? sc_fail : lr_excl_ok, {63'd0, e[0]});
      end
    end
  end

  // driver tasks
  task automatic do_lr(input logic [ADDRW-1:0] a, input int ar_dly, input logic [1:0] resp,
                       input int snoop_mode, input logic exp_ok);
    @(negedge clk);
    lr_req = 1'b1;
    lr_addr = a;
    #1;
    chk("lr_ack", lr_ack, 1);
    chk("lr_ack_sc_ack", sc_ack, 0);
    @(negedge clk);
    lr_req = 1'b0;
    lr_addr = ADDRW'($urandom);
    for (int i = 0; i < ar_dly; i++) begin
      chk("ar_vld_wait", ar_vld, 1);
      chk("ar_lock_wait", ar_lock, 1);
      chk("ar_addr_wait", ar_addr, a);
      @(negedge clk);
    end
    chk("ar_vld", ar_vld, 1);
    chk("ar_addr", ar_addr, a);
    ar_ready = 1'b1;
    @(negedge clk);
    ar_ready = 1'b0;
    chk("ar_vld_drop", ar_vld, 0);
    exp_q.push_back({1'b0, exp_ok});
    if (snoop_mode == 1) begin
      snoop_clr = 1'b1;
      @(negedge clk);
      snoop_clr = 1'b0;
    end
    r_vld = 1'b1;
    r_last = 1'b0;
    r_resp = 2'b01;
    @(negedge clk);
    r_last = 1'b1;
    r_resp = resp;
    snoop_clr = (snoop_mode == 2);
    @(negedge clk);
    r_vld = 1'b0;
    r_last = 1'b0;
    snoop_clr = 1'b0;
    chk("rsv_vld_after_lr", rsv_vld, exp_ok);
    if (exp_ok) chk("rsv_addr_after_lr", rsv_addr, a);
  endtask

  task automatic do_sc(input logic [ADDRW-1:0] a, input logic bus, input int aw_dly,
                       input logic [1:0] bresp, input logic exp_fail);
    @(negedge clk);
    sc_req = 1'b1;
    sc_addr = a;
    #1;
    chk("sc_ack", sc_ack, 1);
    chk("sc_ack_lr_ack", lr_ack, 0);
    if (!bus) exp_q.push_back(2'b11);
    @(negedge clk);
    sc_req = 1'b0;
    if (bus) begin
      for (int i = 0; i < aw_dly; i++) begin
        chk("aw_vld_wait", aw_vld, 1);
        chk("aw_lock_wait", aw_lock, 1);
        chk("aw_addr_wait", aw_addr, a);
        @(negedge clk);
      end
      chk("aw_vld", aw_vld, 1);
      chk("aw_lock", aw_lock, 1);
      aw_ready = 1'b1;
      @(negedge clk);
      aw_ready = 1'b0;
      chk("aw_vld_drop", aw_vld, 0);
      exp_q.push_back({1'b1, exp_fail});
      b_vld = 1'b1;
      b_resp = bresp;
      @(negedge clk);
      b_vld = 1'b0;
    end else begin
      chk("scf_no_aw", aw_vld, 0);
      @(negedge clk);
      chk("scf_no_aw_next", aw_vld, 0);
    end
    chk("rsv_vld_after_sc", rsv_vld, 0);
  endtask

  initial begin
    rst_n = 1'b0;
    lr_req = 1'b0;
    lr_addr = '0;
    sc_req = 1'b0;
    sc_addr = '0;
    snoop_clr = 1'b0;
    ar_ready = 1'b0;
    r_vld = 1'b0;
    r_last = 1'b0;
    r_resp = 2'b00;
    aw_ready = 1'b0;
    b_vld = 1'b0;
    b_resp = 2'b00;
    repeat (3) @(negedge clk);
    chk("rst_ar_vld", ar_vld, 0);
    chk("rst_aw_vld", aw_vld, 0);
    chk("rst_dones", {lr_done, lr_excl_ok, sc_done, sc_fail}, 0);
    chk("rst_rsv", {rsv_vld, rsv_addr}, 0);
    rst_n = 1'b1;
    @(negedge clk);

    // LR ok, then SC hit with EXOKAY
    do_lr(40'h80_0000_1000, 2, 2'b01, 0, 1'b1);
    do_sc(40'h80_0000_1000, 1'b1, 1, 2'b01, 1'b0);

    // SC to a different address fails locally
    do_lr(40'h80_0000_1000, 0, 2'b01, 0, 1'b1);
    do_sc(40'h80_0000_2000, 1'b0, 0, 2'b00, 1'b1);

    // snoop in RWAIT, and snoop together with r_last
    do_lr(40'h80_0000_1040, 1, 2'b01, 1, 1'b0);
    do_lr(40'h80_0000_1080, 0, 2'b01, 2, 1'b0);

    // OKAY / error responses give no reservation; SC then fails locally
    do_lr(40'h12_3456_7000, 1, 2'b00, 0, 1'b0);
    do_sc(40'h12_3456_7000, 1'b0, 0, 2'b00, 1'b1);
    do_lr(40'h12_3456_7100, 0, 2'b10, 0, 1'b0);

    // slave refuses exclusive write
    do_lr(40'h00_0000_3000, 0, 2'b01, 0, 1'b1);
    do_sc(40'h00_0000_3000, 1'b1, 0, 2'b00, 1'b1);

    // snoop in IDLE drops the reservation
    do_lr(40'h00_0000_4000, 0, 2'b01, 0, 1'b1);
    @(negedge clk);
    snoop_clr = 1'b1;
    @(negedge clk);
    snoop_clr = 1'b0;
    chk("snoop_idle_rsv", rsv_vld, 0);

    // stray responses in IDLE are ignored
    r_vld = 1'b1;
    r_last = 1'b1;
    r_resp = 2'b01;
    b_vld = 1'b1;
    b_resp = 2'b01;
    @(negedge clk);
    r_vld = 1'b0;
    r_last = 1'b0;
    b_vld = 1'b0;
    @(negedge clk);
    chk("stray_rsv", rsv_vld, 0);
    chk("stray_ar", ar_vld, 0);

    // SC and LR together: SC wins (no reservation, so local fail)
    @(negedge clk);
    sc_req = 1'b1;
    lr_req = 1'b1;
    sc_addr = 40'h00_0000_5000;
    lr_addr = 40'h00_0000_6000;
    #1;
    chk("both_sc_ack", sc_ack, 1);
    chk("both_lr_ack", lr_ack, 0);
    exp_q.push_back(2'b11);
    @(negedge clk);
    sc_req = 1'b0;
    lr_req = 1'b0;
    chk("both_no_ar", ar_vld, 0);
    @(negedge clk);

    // new LR replaces an existing reservation
    do_lr(40'h00_0000_7000, 0, 2'b01, 0, 1'b1);
    do_lr(40'h00_0000_7100, 0, 2'b00, 0, 1'b0);

    // reset mid-transaction
    @(negedge clk);
    lr_req = 1'b1;
    lr_addr = 40'h00_0000_8000;
    @(negedge clk);
    lr_req = 1'b0;
    chk("pre_rst_ar", ar_vld, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_rst_ar", ar_vld, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ar", ar_vld, 0);

`ifdef CT_CIU_EXCL_TIMEOUT_EN
    do_lr(40'h00_0000_9000, 0, 2'b01, 0, 1'b1);
    repeat (6) @(negedge clk);
    chk("timeout_rsv", rsv_vld, 0);
    do_sc(40'h00_0000_9000, 1'b0, 0, 2'b00, 1'b1);
`endif

    repeat (3) @(negedge clk);
    chk("exp_q_empty", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule
